// File: rtl/pad_pkg.sv
// Shared constants and event type for the controller-to-logical-button mapper.
package pad_pkg;

  localparam int NUM_BTN    = 22;
  localparam int EVT_CODE_W = 5;

  localparam int BTN_A       = 0;
  localparam int BTN_B       = 1;
  localparam int BTN_X       = 2;
  localparam int BTN_Y       = 3;
  localparam int BTN_START   = 4;
  localparam int BTN_L       = 5;
  localparam int BTN_R       = 6;
  localparam int BTN_Z       = 7;
  localparam int BTN_D_UP    = 8;
  localparam int BTN_D_DOWN  = 9;
  localparam int BTN_D_RIGHT = 10;
  localparam int BTN_D_LEFT  = 11;
  localparam int J_UP        = 12;
  localparam int J_DOWN      = 13;
  localparam int J_RIGHT     = 14;
  localparam int J_LEFT      = 15;
  localparam int C_UP        = 16;
  localparam int C_DOWN      = 17;
  localparam int C_RIGHT     = 18;
  localparam int C_LEFT      = 19;
  localparam int LT_A        = 20;
  localparam int RT_A        = 21;

  typedef struct packed {
    logic [EVT_CODE_W-1:0] code;
    logic                  press;
  } pad_evt_t;

endpackage

// File: rtl/pad_evt_fifo.sv
// First-word-fall-through event FIFO; extra pointer bit separates full from empty.
module pad_evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is only observed while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pad_event_mapper.sv
// Decodes controller reports into 22 debounced logical buttons and queues
// every net press/release as an event, lowest index first, one per cycle.
module pad_event_mapper
  import pad_pkg::*;
#(
  parameter int CENTER          = 128,
  parameter int DEADZONE        = 32,
  parameter int TRIG_THRESH     = 128,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rpt_valid,
  input  logic [11:0]           rpt_buttons,
  input  logic [7:0]            rpt_joy_x,
  input  logic [7:0]            rpt_joy_y,
  input  logic [7:0]            rpt_c_x,
  input  logic [7:0]            rpt_c_y,
  input  logic [7:0]            rpt_l_trig,
  input  logic [7:0]            rpt_r_trig,
  output logic [NUM_BTN-1:0]    held,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [EVT_CODE_W-1:0] evt_code,
  output logic                  evt_press,
  output logic                  evt_pending
);

  localparam int         HI     = CENTER + DEADZONE;
  localparam int         LO     = CENTER - DEADZONE;
  localparam bit         HI_OK  = (HI <= 255);
  localparam bit         LO_OK  = (CENTER >= DEADZONE);
  localparam logic [8:0] HI9    = HI_OK ? 9'(HI) : 9'd0;
  localparam logic [8:0] LO9    = LO_OK ? 9'(LO) : 9'd0;
  localparam logic [8:0] TRIG9  = 9'(TRIG_THRESH);
  localparam int         CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_FRAMES);

  function automatic logic ax_hi(input logic [7:0] a);
    return HI_OK && ({1'b0, a} >= HI9);
  endfunction

  function automatic logic ax_lo(input logic [7:0] a);
    return LO_OK && ({1'b0, a} <= LO9);
  endfunction

  logic [NUM_BTN-1:0]    raw;
  logic [NUM_BTN-1:0]    held_q, held_d;
  logic [NUM_BTN-1:0]    pending_q, pending_d;
  logic [NUM_BTN-1:0]    flip, clr;
  logic [CNT_W-1:0]      cnt_q [NUM_BTN];
  logic [CNT_W-1:0]      cnt_d [NUM_BTN];
  logic [EVT_CODE_W-1:0] sel;
  logic                  do_push;
  logic                  fifo_full, fifo_empty;
  pad_evt_t              push_evt, head_evt;

  always_comb begin
    raw          = '0;
    raw[11:0]    = rpt_buttons;
    raw[J_UP]    = ax_hi(rpt_joy_y);
    raw[J_DOWN]  = ax_lo(rpt_joy_y);
    raw[J_RIGHT] = ax_hi(rpt_joy_x);
    raw[J_LEFT]  = ax_lo(rpt_joy_x);
    raw[C_UP]    = ax_hi(rpt_c_y);
    raw[C_DOWN]  = ax_lo(rpt_c_y);
    raw[C_RIGHT] = ax_hi(rpt_c_x);
    raw[C_LEFT]  = ax_lo(rpt_c_x);
    raw[LT_A]    = ({1'b0, rpt_l_trig} >= TRIG9);
    raw[RT_A]    = ({1'b0, rpt_r_trig} >= TRIG9);
  end

  always_comb begin
    flip  = '0;
    cnt_d = cnt_q;
    if (rpt_valid) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (raw[i] == held_q[i]) begin
          cnt_d[i] = '0;
        end else if (CNT_W'(cnt_q[i] + 1'b1) == CNT_TC) begin
          cnt_d[i] = '0;
          flip[i]  = 1'b1;
        end else begin
          cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
        end
      end
    end
    held_d = held_q ^ flip;
  end

  // Pushed polarity is the pre-flip held value; a same-cycle flip re-sets the
  // pending bit through the XOR, so the newer change is emitted later.
  always_comb begin
    sel = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = EVT_CODE_W'(i);
    end
    do_push        = (|pending_q) && !fifo_full;
    push_evt.code  = sel;
    push_evt.press = held_q[sel];
    clr            = do_push ? (NUM_BTN'(1) << sel) : '0;
    pending_d      = pending_q ^ clr ^ flip;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      held_q    <= '0;
      pending_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      held_q    <= held_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  pad_evt_fifo #(
    .WIDTH (EVT_CODE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (do_push),
    .push_data_i (push_evt),
    .pop_i       (evt_ready),
    .head_o      (head_evt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign held        = held_q;
  assign evt_valid   = !fifo_empty;
  assign evt_code    = evt_valid ? head_evt.code : '0;
  assign evt_press   = evt_valid ? head_evt.press : 1'b0;
  assign evt_pending = |pending_q;

endmodule

// File: tb/tb_pad_event_mapper.sv
// Directed scenarios plus random reports, checked every cycle against a
// queue-based reference model of the button/event behaviour.
module tb_pad_event_mapper;

  localparam int CENTER   = 128;
  localparam int DEADZONE = 32;
  localparam int TRIG     = 128;
  localparam int DF       = 2;
  localparam int DEPTH    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rpt_valid;
  logic [11:0] rpt_buttons;
  logic [7:0]  jx, jy, cx, cy, lt, rt;
  logic        evt_ready;
  logic [21:0] held;
  logic        evt_valid, evt_press, evt_pending;
  logic [4:0]  evt_code;

  int n_chk = 0;
  int n_err = 0;

  logic [21:0] m_held, m_pend;
  int          m_cnt [22];
  int          m_q [$];
  int          deliv [$];

  pad_event_mapper #(
    .CENTER (CENTER), .DEADZONE (DEADZONE), .TRIG_THRESH (TRIG),
    .DEBOUNCE_FRAMES (DF), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .reset (reset), .rpt_valid (rpt_valid),
    .rpt_buttons (rpt_buttons), .rpt_joy_x (jx), .rpt_joy_y (jy),
    .rpt_c_x (cx), .rpt_c_y (cy), .rpt_l_trig (lt), .rpt_r_trig (rt),
    .held (held), .evt_valid (evt_valid), .evt_ready (evt_ready),
    .evt_code (evt_code), .evt_press (evt_press), .evt_pending (evt_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [21:0] m_raw();
    logic [21:0] r;
    r[11:0] = rpt_buttons;
    r[12] = int'(jy) >= CENTER + DEADZONE;
    r[13] = int'(jy) <= CENTER - DEADZONE;
    r[14] = int'(jx) >= CENTER + DEADZONE;
    r[15] = int'(jx) <= CENTER - DEADZONE;
    r[16] = int'(cy) >= CENTER + DEADZONE;
    r[17] = int'(cy) <= CENTER - DEADZONE;
    r[18] = int'(cx) >= CENTER + DEADZONE;
    r[19] = int'(cx) <= CENTER - DEADZONE;
    r[20] = int'(lt) >= TRIG;
    r[21] = int'(rt) >= TRIG;
    return r;
  endfunction

  // One clock: advance the model with the current inputs, then compare.
  task automatic step();
    logic [21:0] raw;
    int          idx;
    int          ev;
    bit          pushed;
    bit          popped;
    pushed = 0;
    if (reset && evt_valid && evt_ready) deliv.push_back(int'({evt_code, evt_press}));
    if (!reset) begin
      m_held = '0;
      m_pend = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_q.delete();
    end else begin
      raw    = m_raw();
      popped = (m_q.size() > 0) && evt_ready;
      idx    = -1;
      for (int i = 0; i < 22; i++) if (m_pend[i] && idx < 0) idx = i;
      if (idx >= 0 && m_q.size() < DEPTH) begin
        ev        = idx * 2 + int'(m_held[idx]);
        pushed    = 1;
        m_pend[idx] = 1'b0;
      end
      if (rpt_valid) begin
        for (int i = 0; i < 22; i++) begin
          if (raw[i] == m_held[i]) m_cnt[i] = 0;
          else begin
            m_cnt[i]++;
            if (m_cnt[i] == DF) begin
              m_cnt[i]  = 0;
              m_held[i] = ~m_held[i];
              m_pend[i] = ~m_pend[i];
            end
          end
        end
      end
      if (popped) void'(m_q.pop_front());
      if (pushed) m_q.push_back(ev);
    end
    @(posedge clk);
    #1;
    chk("held", held, m_held);
    chk("evt_valid", evt_valid, m_q.size() > 0);
    chk("evt_pending", evt_pending, |m_pend);
    if (m_q.size() > 0) begin
      chk("evt_code", evt_code, m_q[0] >> 1);
      chk("evt_press", evt_press, m_q[0] & 1);
    end else if (!reset) begin
      chk("rst_code", evt_code, 0);
      chk("rst_press", evt_press, 0);
    end
  endtask

  task automatic idle(input int n);
    rpt_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic rep2();
    rpt_valid = 1'b1;
    step();
    step();
    rpt_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rpt_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic logic [7:0] pick_ax();
    case ($urandom_range(0, 7))
      0: return 8'd96;
      1: return 8'd97;
      2: return 8'd128;
      3: return 8'd159;
      4: return 8'd160;
      5: return 8'd0;
      6: return 8'd255;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0] sweep [4];
    bit         saw_b;
    reset = 1'b0; rpt_valid = 1'b0; rpt_buttons = '0; evt_ready = 1'b0;
    jx = 8'd128; jy = 8'd128; cx = 8'd128; cy = 8'd128; lt = '0; rt = '0;
    m_held = '0; m_pend = '0;
    foreach (m_cnt[i]) m_cnt[i] = 0;

    do_reset();
    chk("reset_held", held, 0);
    chk("reset_valid", evt_valid, 0);
    chk("reset_pending", evt_pending, 0);

    // A press with two-report debounce
    rpt_buttons = 12'h001;
    rpt_valid = 1'b1; step();
    chk("a_held_1st", held[0], 0);
    step();
    chk("a_held_2nd", held[0], 1);
    chk("a_no_evt_yet", evt_valid, 0);
    rpt_valid = 1'b0; step();
    chk("a_evt_valid", evt_valid, 1);
    chk("a_evt_code", evt_code, 0);
    chk("a_evt_press", evt_press, 1);
    evt_ready = 1'b1; idle(3);
    chk("a_drained", evt_valid, 0);

    // Main-stick X threshold sweep
    do_reset();
    rpt_buttons = '0;
    sweep[0] = 8'd159; sweep[1] = 8'd160; sweep[2] = 8'd96; sweep[3] = 8'd97;
    for (int s = 0; s < 4; s++) begin
      jx = sweep[s];
      rep2();
      rep2();
      chk("sweep_right", held[14], s == 1);
      chk("sweep_left", held[15], s == 2);
    end
    jx = 8'd128;
    idle(4);

    // A, Z, RT_A flipped by one repeated report
    do_reset();
    deliv.delete();
    rpt_buttons = 12'h081; rt = 8'd200;
    rep2();
    idle(6);
    chk("azr_count", deliv.size(), 3);
    if (deliv.size() == 3) begin
      chk("azr_ev0", deliv[0], 0 * 2 + 1);
      chk("azr_ev1", deliv[1], 7 * 2 + 1);
      chk("azr_ev2", deliv[2], 21 * 2 + 1);
    end
    rt = '0;

    // Backpressure: 12 presses with the consumer stalled
    do_reset();
    evt_ready = 1'b0;
    rpt_buttons = 12'hFFF;
    rep2();
    idle(12);
    chk("bp_pending", evt_pending, 1);
    chk("bp_valid", evt_valid, 1);
    deliv.delete();
    evt_ready = 1'b1;
    idle(20);
    chk("bp_count", deliv.size(), 12);
    for (int k = 0; k < 12 && k < deliv.size(); k++) chk("bp_order", deliv[k], k * 2 + 1);

    // B pressed and released while the FIFO is full: must cancel
    do_reset();
    evt_ready = 1'b0;
    rpt_buttons = 12'hFFD;
    rep2();
    idle(10);
    rpt_buttons = 12'hFFF;
    rep2();
    chk("b_held_on", held[1], 1);
    rpt_buttons = 12'hFFD;
    rep2();
    chk("b_held_off", held[1], 0);
    deliv.delete();
    evt_ready = 1'b1;
    idle(20);
    saw_b = 0;
    foreach (deliv[k]) if ((deliv[k] >> 1) == 1) saw_b = 1;
    chk("b_cancelled", saw_b, 0);
    chk("b_count", deliv.size(), 11);

    // Reset while events are queued
    do_reset();
    evt_ready = 1'b0;
    rpt_buttons = 12'h01F;
    rep2();
    idle(7);
    chk("rq_queued", evt_valid, 1);
    reset = 1'b0; step();
    chk("rq_valid", evt_valid, 0);
    chk("rq_held", held, 0);
    reset = 1'b1;
    evt_ready = 1'b1;
    idle(5);
    chk("rq_stale", evt_valid, 0);
    chk("rq_pending", evt_pending, 0);

    // Random reports, stalls and occasional resets
    for (int c = 0; c < 4000; c++) begin
      rpt_valid = ($urandom_range(0, 2) == 0);
      evt_ready = ($urandom_range(0, 9) < 6);
      reset     = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 5) == 0) rpt_buttons = rpt_buttons ^ (12'h1 << $urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) jx = pick_ax();
      if ($urandom_range(0, 7) == 0) jy = pick_ax();
      if ($urandom_range(0, 7) == 0) cx = pick_ax();
      if ($urandom_range(0, 7) == 0) cy = pick_ax();
      if ($urandom_range(0, 9) == 0) lt = ($urandom_range(0, 1) != 0) ? 8'd128 : 8'd127;
      if ($urandom_range(0, 9) == 0) rt = 8'($urandom_range(0, 255));
      step();
    end
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
